wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage, directly downstream of the memory stage in the handshaked multi-cycle RV64I core.
- Accepts one instruction per memoryed req/ack handshake.
- Selects load data or the execute result, then applies byte-lane selection and sign or zero extension for loads.
- Writes the register file, counts retired instructions, and signals completion downstream (commit/difftest) with a writebacked req/ack handshake.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- RETIRE_INIT, 0, reset value of the retire counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wb_memoryed_req_i  in  1  upstream has a valid instruction (level, held until acked)
- wb_memoryed_ack_o  out  1  stage ready to accept
- wb_writebacked_req_o  out  1  instruction written back, awaiting downstream ack
- wb_writebacked_ack_i  in  1  downstream accepts
- wb_pc_i  in  64  instruction PC
- wb_inst_i  in  32  instruction word
- wb_rd_i  in  5  destination register
- wb_rd_wen_i  in  1  instruction writes rd
- wb_exe_data_i  in  64  ALU/jump result
- wb_mem_ren_i  in  1  instruction is a load
- wb_mem_funct3_i  in  3  load width/sign
- wb_mem_addr_i  in  64  load address; only [2:0] used
- wb_mem_rdata_i  in  64  aligned doubleword from memory stage
- rf_wen_o  out  1  register-file write strobe
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  64  register-file write data
- wb_pc_o  out  64  retired PC
- wb_inst_o  out  32  retired instruction
- wb_retire_cnt_o  out  64  instructions retired since reset

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. In reset:
  - state=IDLE
  - all outputs 0, except wb_memoryed_ack_o=1 and wb_retire_cnt_o=RETIRE_INIT
  - all latches cleared
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - wb_memoryed_ack_o=1.
  - On req_i&ack_o (handshake, cycle N): latch pc, inst, rd, rd_wen, mem_ren, funct3, addr[2:0], exe_data and mem_rdata.
  - Go to WRITE.
- WRITE (cycle N+1):
  - wb_memoryed_ack_o=0.
  - rf_wen_o=1 only if latched rd_wen=1 and rd!=0. rf_waddr_o=rd.
  - rf_wdata_o = load_result if mem_ren, else exe_data.
  - wb_retire_cnt_o increments by 1; wraps 2^64-1 -> 0.
  - Go to DONE.
- DONE (from N+2):
  - wb_writebacked_req_o=1. wb_pc_o and wb_inst_o hold the latched values.
  - Stay until wb_writebacked_ack_i=1; that cycle go to IDLE, and req_o drops the next cycle.
- rf_wen_o is a single-cycle pulse. rf_waddr_o and rf_wdata_o are don't-care outside WRITE but must not glitch while rf_wen_o=1.
- Load extension, with lane shift = addr[2:0]*8 applied to the latched rdata:
  - 000 LB: sign-extend 8 bits
  - 001 LH: sign-extend 16 bits
  - 010 LW: sign-extend 32 bits
  - 011 LD: full 64 bits
  - 100 LBU, 101 LHU, 110 LWU: zero-extend
  - 111: result 0
- Misaligned loads are not detected here; the shifted data is used as-is.
- wb_memoryed_ack_o=0 in WRITE and DONE. An upstream req asserted then is not accepted until IDLE, so at most one instruction is in flight.
- An ack_i arriving while not in DONE is ignored.
- rst asserted in any state (including DONE with req_o high) returns to reset values next cycle. There is no rf write and no count increment.
- Throughput: one instruction per 3 cycles minimum (ack_i tied high).

Decomposition:
- defines.v (shared):
  - BUS_64 and REG_BUS widths
  - load funct3 constants (LB..LWU)
  - FSM state encodings for wb_stage
- One sub-module: load_ext (combinational). Inputs funct3, addr[2:0] and rdata; output is the 64-bit extended value. Verified standalone.

Test Plan:
- ALU write: exe_data=0x1234, rd=5, rd_wen=1, mem_ren=0, ack_i=1 -> rf_wen_o pulse at N+1, waddr=5, wdata=0x1234; req_o at N+2; retire_cnt=1.
- LB negative: rdata=0x80FF_0000_0000_0000, addr[2:0]=7, funct3=000 -> wdata=0xFFFF_FFFF_FFFF_FF80. Same inputs with funct3=100 -> wdata=0x80.
- LWU/LW lane: rdata=0x8765_4321_0000_0000, addr[2:0]=4 -> LWU wdata=0x0000_0000_8765_4321; LW wdata=0xFFFF_FFFF_8765_4321.
- rd=0 with rd_wen=1: rf_wen_o stays 0; retire_cnt still increments; req/ack completes.
- Backpressure: ack_i held 0 for 5 cycles while upstream req_i=1 -> req_o held and memoryed_ack_o=0 throughout. On ack_i=1: IDLE the next cycle, then the new instruction is accepted.
- Reset mid-DONE: rst pulsed while req_o=1 -> next cycle req_o=0, ack_o=1, retire_cnt=0, no rf_wen_o pulse.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
// Widths, load funct3 codes, FSM encoding, latched bundle.
package wb_stage_pkg;

  localparam int BUS_64  = 64;
  localparam int REG_BUS = 64;
  localparam int REG_AW  = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [BUS_64-1:0]  pc;
    logic [31:0]        inst;
    logic [REG_AW-1:0]  rd;
    logic               rd_wen;
    logic               mem_ren;
    logic [2:0]         funct3;
    logic [2:0]         addr;
    logic [REG_BUS-1:0] exe;
    logic [BUS_64-1:0]  rdata;
  } wb_lat_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load lane select and sign/zero extension (combinational).
// In: funct3_i, addr_i[2:0], rdata_i. Out: data_o.
module wb_stage_load_ext
  import wb_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  addr_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] data_o
);

  logic [63:0] lane;

  assign lane = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    data_o = '0;
    unique case (funct3_i)
      F3_LB:   data_o = {{56{lane[7]}}, lane[7:0]};
      F3_LH:   data_o = {{48{lane[15]}}, lane[15:0]};
      F3_LW:   data_o = {{32{lane[31]}}, lane[31:0]};
      F3_LD:   data_o = lane;
      F3_LBU:  data_o = {56'd0, lane[7:0]};
      F3_LHU:  data_o = {48'd0, lane[15:0]};
      F3_LWU:  data_o = {32'd0, lane[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: latch, write rf, count retires, handshake out.
// Ports: memoryed req/ack in, writebacked req/ack out, rf write, pc/inst/count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter logic [63:0] RETIRE_INIT = 64'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_memoryed_req_i,
  output logic            wb_memoryed_ack_o,
  output logic            wb_writebacked_req_o,
  input  logic            wb_writebacked_ack_i,
  input  logic [XLEN-1:0] wb_pc_i,
  input  logic [31:0]     wb_inst_i,
  input  logic [4:0]      wb_rd_i,
  input  logic            wb_rd_wen_i,
  input  logic [XLEN-1:0] wb_exe_data_i,
  input  logic            wb_mem_ren_i,
  input  logic [2:0]      wb_mem_funct3_i,
  input  logic [XLEN-1:0] wb_mem_addr_i,
  input  logic [XLEN-1:0] wb_mem_rdata_i,
  output logic            rf_wen_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic [31:0]     wb_inst_o,
  output logic [XLEN-1:0] wb_retire_cnt_o
);

  wb_state_e   state_q, state_d;
  wb_lat_t     lat_q, lat_d;
  logic [63:0] cnt_q, cnt_d;
  logic [63:0] ld_data;
  logic        unused_addr;

  assign unused_addr = ^wb_mem_addr_i[XLEN-1:3];

  wb_stage_load_ext u_load_ext (
    .funct3_i (lat_q.funct3),
    .addr_i   (lat_q.addr),
    .rdata_i  (lat_q.rdata),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_memoryed_req_i) begin
          lat_d.pc      = wb_pc_i;
          lat_d.inst    = wb_inst_i;
          lat_d.rd      = wb_rd_i;
          lat_d.rd_wen  = wb_rd_wen_i;
          lat_d.mem_ren = wb_mem_ren_i;
          lat_d.funct3  = wb_mem_funct3_i;
          lat_d.addr    = wb_mem_addr_i[2:0];
          lat_d.exe     = wb_exe_data_i;
          lat_d.rdata   = wb_mem_rdata_i;
          state_d       = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d   = cnt_q + 64'd1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (wb_writebacked_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      cnt_q   <= RETIRE_INIT;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by rst so a reset landing in WRITE never commits to the rf.
  assign rf_wen_o = (state_q == ST_WRITE) && lat_q.rd_wen
                    && (lat_q.rd != 5'd0) && !rst;

  assign wb_memoryed_ack_o    = (state_q == ST_IDLE);
  assign wb_writebacked_req_o = (state_q == ST_DONE);
  assign rf_waddr_o           = lat_q.rd;
  assign rf_wdata_o = lat_q.mem_ren ? ld_data : lat_q.exe;
  assign wb_pc_o              = lat_q.pc;
  assign wb_inst_o            = lat_q.inst;
  assign wb_retire_cnt_o      = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage.
// Scoreboard of expected rf writes, popped in the WRITE cycle.
module tb_wb_stage;

  localparam logic [63:0] RINIT = 64'hFFFF_FFFF_FFFF_FFFE;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        ack_o;
  logic        req_o;
  logic        ack_i;
  logic [63:0] pc_i;
  logic [31:0] inst_i;
  logic [4:0]  rd_i;
  logic        rd_wen_i;
  logic [63:0] exe_i;
  logic        ren_i;
  logic [2:0]  f3_i;
  logic [63:0] addr_i;
  logic [63:0] rdata_i;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic [63:0] cnt_o;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_fails;
  logic [63:0] exp_cnt;

  wb_stage #(.XLEN(64), .RETIRE_INIT(RINIT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wb_memoryed_req_i    (req_i),
    .wb_memoryed_ack_o    (ack_o),
    .wb_writebacked_req_o (req_o),
    .wb_writebacked_ack_i (ack_i),
    .wb_pc_i              (pc_i),
    .wb_inst_i            (inst_i),
    .wb_rd_i              (rd_i),
    .wb_rd_wen_i          (rd_wen_i),
    .wb_exe_data_i        (exe_i),
    .wb_mem_ren_i         (ren_i),
    .wb_mem_funct3_i      (f3_i),
    .wb_mem_addr_i        (addr_i),
    .wb_mem_rdata_i       (rdata_i),
    .rf_wen_o             (rf_wen),
    .rf_waddr_o           (rf_waddr),
    .rf_wdata_o           (rf_wdata),
    .wb_pc_o              (pc_o),
    .wb_inst_o            (inst_o),
    .wb_retire_cnt_o      (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic scramble();
    pc_i     = {$urandom, $urandom};
    inst_i   = $urandom;
    rd_i     = 5'($urandom);
    rd_wen_i = 1'($urandom);
    exe_i    = {$urandom, $urandom};
    ren_i    = 1'($urandom);
    f3_i     = 3'($urandom);
    addr_i   = {$urandom, $urandom};
    rdata_i  = {$urandom, $urandom};
  endtask

  // Called at a negedge with the DUT in IDLE; returns likewise.
  task automatic run_inst(
    input string       name,
    input logic [63:0] pc,
    input logic [31:0] inst,
    input logic [4:0]  rd,
    input logic        rd_wen,
    input logic [63:0] exe,
    input logic        ren,
    input logic [2:0]  f3,
    input logic [2:0]  alo,
    input logic [63:0] rdata,
    input logic [63:0] exp_wdata,
    input int          hold,
    input logic        early_ack
  );
    exp_t e;
    exp_t g;
    e.wen   = rd_wen && (rd != 5'd0);
    e.waddr = rd;
    e.wdata = exp_wdata;
    e.pc    = pc;
    e.inst  = inst;
    sb.push_back(e);
    req_i    = 1'b1;
    pc_i     = pc;
    inst_i   = inst;
    rd_i     = rd;
    rd_wen_i = rd_wen;
    exe_i    = exe;
    ren_i    = ren;
    f3_i     = f3;
    addr_i   = {$urandom, 29'($urandom), alo};
    rdata_i  = rdata;
    #1;
    n_checks++;
    if (ack_o !== 1'b1) begin
      n_fails++;
      $display("FAIL %s idle_ack: got %b exp 1", name, ack_o);
    end
    @(negedge clk);
    req_i = 1'b0;
    scramble();
    ack_i = early_ack;
    n_checks++;
    if (sb.size() == 0) begin
      n_fails++;
      $display("FAIL %s sb_empty: got 0 exp 1 entries", name);
    end else begin
      g = sb.pop_front();
      if (rf_wen !== g.wen || rf_waddr !== g.waddr
          || rf_wdata !== g.wdata || ack_o !== 1'b0) begin
        n_fails++;
        $display("FAIL %s write: got wen=%b a=%0d d=%h ack=%b exp wen=%b a=%0d d=%h ack=0",
                 name, rf_wen, rf_waddr, rf_wdata, ack_o,
                 g.wen, g.waddr, g.wdata);
      end
    end
    exp_cnt = exp_cnt + 64'd1;
    @(negedge clk);
    ack_i = 1'b0;
    n_checks++;
    if (req_o !== 1'b1 || ack_o !== 1'b0 || rf_wen !== 1'b0
        || pc_o !== e.pc || inst_o !== e.inst || cnt_o !== exp_cnt) begin
      n_fails++;
      $display("FAIL %s done: got req=%b ack=%b wen=%b pc=%h inst=%h cnt=%h exp 1 0 0 %h %h %h",
               name, req_o, ack_o, rf_wen, pc_o, inst_o, cnt_o,
               e.pc, e.inst, exp_cnt);
    end
    for (int i = 0; i < hold; i++) begin
      req_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_o !== 1'b1 || ack_o !== 1'b0 || rf_wen !== 1'b0
          || cnt_o !== exp_cnt || pc_o !== e.pc) begin
        n_fails++;
        $display("FAIL %s hold%0d: got req=%b ack=%b wen=%b cnt=%h exp 1 0 0 %h",
                 name, i, req_o, ack_o, rf_wen, cnt_o, exp_cnt);
      end
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    n_checks++;
    if (req_o !== 1'b0 || ack_o !== 1'b1 || rf_wen !== 1'b0) begin
      n_fails++;
      $display("FAIL %s back_idle: got req=%b ack=%b wen=%b exp 0 1 0",
               name, req_o, ack_o, rf_wen);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req_i = 1'b0;
    ack_i = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    n_checks++;
    if (ack_o !== 1'b1 || req_o !== 1'b0 || rf_wen !== 1'b0
        || pc_o !== 64'd0 || inst_o !== 32'd0 || cnt_o !== RINIT
        || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
      n_fails++;
      $display("FAIL reset: got ack=%b req=%b wen=%b pc=%h inst=%h cnt=%h exp 1 0 0 0 0 %h",
               ack_o, req_o, rf_wen, pc_o, inst_o, cnt_o, RINIT);
    end
    rst     = 1'b0;
    exp_cnt = RINIT;
  endtask

  task automatic test_alu();
    run_inst("alu", 64'h8000_0000, 32'h0000_1293, 5'd5, 1'b1,
             64'h1234, 1'b0, 3'b000, 3'd0, 64'hDEAD_BEEF_0000_0000,
             64'h1234, 0, 1'b0);
  endtask

  task automatic test_loads();
    logic [63:0] tab[8];
    run_inst("lb_neg", 64'h100, 32'h0070_0283, 5'd7, 1'b1,
             64'h5555, 1'b1, 3'b000, 3'd7, 64'h80FF_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FF80, 0, 1'b0);
    run_inst("lbu", 64'h104, 32'h0070_4283, 5'd8, 1'b1,
             64'h5555, 1'b1, 3'b100, 3'd7, 64'h80FF_0000_0000_0000,
             64'h80, 0, 1'b0);
    run_inst("lwu", 64'h108, 32'h0040_6283, 5'd9, 1'b1,
             64'h5555, 1'b1, 3'b110, 3'd4, 64'h8765_4321_0000_0000,
             64'h0000_0000_8765_4321, 0, 1'b0);
    run_inst("lw", 64'h10C, 32'h0040_2283, 5'd10, 1'b1,
             64'h5555, 1'b1, 3'b010, 3'd4, 64'h8765_4321_0000_0000,
             64'hFFFF_FFFF_8765_4321, 0, 1'b0);
    tab[0] = 64'hFFFF_FFFF_FFFF_FF96;
    tab[1] = 64'hFFFF_FFFF_FFFF_A596;
    tab[2] = 64'hFFFF_FFFF_C3B4_A596;
    tab[3] = 64'h00F0_E1D2_C3B4_A596;
    tab[4] = 64'h0000_0000_0000_0096;
    tab[5] = 64'h0000_0000_0000_A596;
    tab[6] = 64'h0000_0000_C3B4_A596;
    tab[7] = 64'h0;
    for (int f = 0; f < 8; f++) begin
      run_inst($sformatf("ld_f3_%0d", f), 64'h200 + 64'(f * 4),
               32'h0000_0003, 5'(11 + f), 1'b1, 64'hABCD,
               1'b1, 3'(f), 3'd1, 64'hF0E1_D2C3_B4A5_9687,
               tab[f], 0, 1'b0);
    end
  endtask

  task automatic test_rd_zero();
    run_inst("rd_zero", 64'h300, 32'h0000_0013, 5'd0, 1'b1,
             64'hDEAD, 1'b0, 3'b000, 3'd0, 64'h0,
             64'hDEAD, 0, 1'b0);
    run_inst("rd_wen_0", 64'h304, 32'h0000_0063, 5'd3, 1'b0,
             64'hBEEF, 1'b0, 3'b000, 3'd0, 64'h0,
             64'hBEEF, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_inst("bp", 64'h400, 32'h0010_0093, 5'd1, 1'b1,
             64'h77, 1'b0, 3'b000, 3'd0, 64'h0,
             64'h77, 5, 1'b1);
    run_inst("bp_next", 64'h404, 32'h0020_0113, 5'd2, 1'b1,
             64'h88, 1'b0, 3'b000, 3'd0, 64'h0,
             64'h88, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] x;
    logic [4:0]  r;
    for (int i = 0; i < 6; i++) begin
      x = {$urandom, $urandom};
      r = 5'($urandom_range(1, 31));
      run_inst($sformatf("b2b_%0d", i), 64'h500 + 64'(i * 4),
               $urandom, r, 1'b1, x, 1'b0, 3'($urandom),
               3'($urandom), {$urandom, $urandom}, x, 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_done();
    req_i    = 1'b1;
    pc_i     = 64'h600;
    inst_i   = 32'h0050_0293;
    rd_i     = 5'd5;
    rd_wen_i = 1'b1;
    exe_i    = 64'h99;
    ren_i    = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_o !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_done_pre: got req=%b exp 1", req_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = RINIT;
    n_checks++;
    if (req_o !== 1'b0 || ack_o !== 1'b1 || cnt_o !== RINIT
        || rf_wen !== 1'b0 || pc_o !== 64'd0 || inst_o !== 32'd0) begin
      n_fails++;
      $display("FAIL rst_done: got req=%b ack=%b cnt=%h wen=%b pc=%h exp 0 1 %h 0 0",
               req_o, ack_o, cnt_o, rf_wen, pc_o, RINIT);
    end
    @(negedge clk);
    n_checks++;
    if (rf_wen !== 1'b0 || req_o !== 1'b0 || cnt_o !== RINIT) begin
      n_fails++;
      $display("FAIL rst_done_post: got wen=%b req=%b cnt=%h exp 0 0 %h",
               rf_wen, req_o, cnt_o, RINIT);
    end
  endtask

  task automatic test_reset_in_write();
    req_i    = 1'b1;
    pc_i     = 64'h700;
    inst_i   = 32'h0060_0313;
    rd_i     = 5'd6;
    rd_wen_i = 1'b1;
    exe_i    = 64'hAA;
    ren_i    = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    rst   = 1'b1;
    #1;
    n_checks++;
    if (rf_wen !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_write_wen: got %b exp 0", rf_wen);
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (cnt_o !== RINIT || req_o !== 1'b0 || ack_o !== 1'b1
        || rf_wen !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_write: got cnt=%h req=%b ack=%b wen=%b exp %h 0 1 0",
               cnt_o, req_o, ack_o, rf_wen, RINIT);
    end
    exp_cnt = RINIT;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_cnt  = RINIT;
    test_reset();
    test_alu();
    test_loads();
    test_rd_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_done();
    test_reset_in_write();
    test_alu();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
